// File: rtl/ctrl_convseq.sv
// Polyphase convolution sequencer: steps the RAM driver through INIT/CALC/RESULT/RELOAD per sample.
// Optional CALC watchdog enabled by defining CTRL_CONVSEQ_WDT_EN.
module ctrl_convseq #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned PHASE_WIDTH = 4,
  parameter int unsigned WDT_WIDTH   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  cfg_bptr,
  input  logic [ADDR_WIDTH-1:0]  cfg_lptr,
  input  logic [ADDR_WIDTH-1:0]  cfg_coef_base,
  input  logic [ADDR_WIDTH-1:0]  cfg_tap_len,
  input  logic [PHASE_WIDTH-1:0] cfg_phases,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   conv_pass,
  output logic                   en_init,
  output logic                   ringbuf_init,
  output logic                   en_calc,
  output logic                   coeff_load,
  output logic [ADDR_WIDTH-1:0]  data_hptr,
  output logic [ADDR_WIDTH-1:0]  coef_ptr,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   res_last,
  output logic                   busy,
  output logic                   wdt_err
);

  typedef enum logic [2:0] {StIdle, StInit, StCalc, StResult, StReload} state_e;

  state_e                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d, last_phase;
  logic [ADDR_WIDTH-1:0]  hptr_q, hptr_d, hptr_adv;
  logic [ADDR_WIDTH-1:0]  coef_q, coef_d;
  logic                   s_ready_q, en_init_q, ringbuf_init_q, en_calc_q, coeff_load_q;
  logic                   res_valid_q, res_last_q, busy_q;

  if (WDT_WIDTH < 2) begin : g_bad_wdt_width
    $error("WDT_WIDTH must be at least 2");
  end

`ifdef CTRL_CONVSEQ_WDT_EN
  logic [WDT_WIDTH-1:0] wdt_q, wdt_d, wdt_inc;
  logic                 wdt_err_q, wdt_err_d;
`endif

  // A phase count of zero is treated as a single phase.
  assign last_phase = (cfg_phases == '0) ? '0 : cfg_phases - PHASE_WIDTH'(1);
  assign hptr_adv   = (hptr_q == cfg_lptr) ? cfg_bptr : hptr_q + ADDR_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    coef_d  = coef_q;
    hptr_d  = hptr_q;
`ifdef CTRL_CONVSEQ_WDT_EN
    wdt_inc   = wdt_q + WDT_WIDTH'(1);
    wdt_d     = wdt_q;
    wdt_err_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (s_valid) begin
          state_d = StInit;
          phase_d = '0;
          coef_d  = cfg_coef_base;
        end
      end
      StInit: begin
        state_d = StCalc;
`ifdef CTRL_CONVSEQ_WDT_EN
        wdt_d = '0;
`endif
      end
      StCalc: begin
        if (conv_pass) begin
          state_d = StResult;
`ifdef CTRL_CONVSEQ_WDT_EN
        end else if (&wdt_inc) begin
          // Abort the sample but still consume its ring buffer slot.
          state_d   = StIdle;
          wdt_err_d = 1'b1;
          phase_d   = '0;
          coef_d    = cfg_coef_base;
          hptr_d    = hptr_adv;
        end else begin
          wdt_d = wdt_inc;
`endif
        end
      end
      StResult: begin
        if (res_ready) begin
          if (phase_q == last_phase) begin
            state_d = StIdle;
            phase_d = '0;
            coef_d  = cfg_coef_base;
            hptr_d  = hptr_adv;
          end else begin
            state_d = StReload;
            phase_d = phase_q + PHASE_WIDTH'(1);
            coef_d  = coef_q + cfg_tap_len;
          end
        end
      end
      StReload: begin
        state_d = StCalc;
`ifdef CTRL_CONVSEQ_WDT_EN
        wdt_d = '0;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they are pure Moore functions of state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      phase_q        <= '0;
      hptr_q         <= cfg_bptr;
      coef_q         <= cfg_coef_base;
      s_ready_q      <= 1'b1;
      en_init_q      <= 1'b0;
      ringbuf_init_q <= 1'b0;
      en_calc_q      <= 1'b0;
      coeff_load_q   <= 1'b0;
      res_valid_q    <= 1'b0;
      res_last_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      hptr_q         <= hptr_d;
      coef_q         <= coef_d;
      s_ready_q      <= (state_d == StIdle);
      en_init_q      <= (state_d == StInit);
      ringbuf_init_q <= (state_d == StInit);
      en_calc_q      <= (state_d == StCalc);
      coeff_load_q   <= (state_d == StInit) || (state_d == StReload);
      res_valid_q    <= (state_d == StResult);
      res_last_q     <= (state_d == StResult) && (phase_d == last_phase);
      busy_q         <= (state_d != StIdle);
    end
  end

`ifdef CTRL_CONVSEQ_WDT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_q     <= '0;
      wdt_err_q <= 1'b0;
    end else begin
      wdt_q     <= wdt_d;
      wdt_err_q <= wdt_err_d;
    end
  end

  assign wdt_err = wdt_err_q;
`else
  assign wdt_err = 1'b0;
`endif

  assign s_ready      = s_ready_q;
  assign en_init      = en_init_q;
  assign ringbuf_init = ringbuf_init_q;
  assign en_calc      = en_calc_q;
  assign coeff_load   = coeff_load_q;
  assign data_hptr    = hptr_q;
  assign coef_ptr     = coef_q;
  assign phase        = phase_q;
  assign res_valid    = res_valid_q;
  assign res_last     = res_last_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_ctrl_convseq.sv
// Self-checking bench for ctrl_convseq: vector table per sample plus hand-written corner sequences.
// Results are checked by a scoreboard filled when each sample is offered.
module tb_ctrl_convseq;

`ifdef CTRL_CONVSEQ_WDT_EN
  localparam int unsigned TbWdt = 4;
`else
  localparam int unsigned TbWdt = 10;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] cfg_bptr, cfg_lptr, cfg_coef_base, cfg_tap_len;
  logic [3:0]  cfg_phases;
  logic        s_valid, s_ready, conv_pass;
  logic        en_init, ringbuf_init, en_calc, coeff_load;
  logic [11:0] data_hptr, coef_ptr;
  logic [3:0]  phase;
  logic        res_valid, res_ready, res_last, busy, wdt_err;

  ctrl_convseq #(
    .ADDR_WIDTH (12),
    .PHASE_WIDTH(4),
    .WDT_WIDTH  (TbWdt)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_bptr     (cfg_bptr),
    .cfg_lptr     (cfg_lptr),
    .cfg_coef_base(cfg_coef_base),
    .cfg_tap_len  (cfg_tap_len),
    .cfg_phases   (cfg_phases),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .conv_pass    (conv_pass),
    .en_init      (en_init),
    .ringbuf_init (ringbuf_init),
    .en_calc      (en_calc),
    .coeff_load   (coeff_load),
    .data_hptr    (data_hptr),
    .coef_ptr     (coef_ptr),
    .phase        (phase),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_last     (res_last),
    .busy         (busy),
    .wdt_err      (wdt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  phases;
    logic [11:0] base;
    logic [11:0] tap;
    int          calc_n;
    int          ready_wait;
    bit          sv_busy;
    logic [11:0] exp_hptr;
  } vec_t;

  typedef struct {
    logic [11:0] coef;
    logic [3:0]  phase;
    logic        last;
    logic [11:0] hptr;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic        rv_prev = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [11:0] m_hptr;
  vec_t        vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] adv(input logic [11:0] h);
    return (h == cfg_lptr) ? cfg_bptr : h + 12'd1;
  endfunction

  // Scoreboard: compare on the first cycle of each res_valid pulse.
  always @(negedge clk) begin
    if (res_valid && !rv_prev) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL res_unexpected: got res_valid with phase %0d, expected none", phase);
      end else begin
        mon_e = sb_q.pop_front();
        check("res_coef_ptr", coef_ptr, mon_e.coef);
        check("res_phase", phase, mon_e.phase);
        check("res_last", res_last, mon_e.last);
        check("res_data_hptr", data_hptr, mon_e.hptr);
      end
    end
    rv_prev = res_valid;
  end

  task automatic wait_ready();
    int waited = 0;
    while (!s_ready && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    check("accept_s_ready", s_ready, 1);
  endtask

  task automatic do_sample(input vec_t v);
    int          eff;
    logic [11:0] c;
    cfg_phases    = v.phases;
    cfg_coef_base = v.base;
    cfg_tap_len   = v.tap;
    eff = (v.phases == 0) ? 1 : int'(v.phases);
    wait_ready();
    s_valid = 1'b1;
    c = v.base;
    for (int p = 0; p < eff; p++) begin
      sb_q.push_back('{coef: c, phase: p[3:0], last: (p == eff - 1), hptr: m_hptr});
      c = c + v.tap;
    end
    @(negedge clk);
    if (!v.sv_busy) s_valid = 1'b0;
    check("init_en_init", en_init, 1);
    check("init_ringbuf", ringbuf_init, 1);
    check("init_coeff_load", coeff_load, 1);
    check("init_en_calc", en_calc, 0);
    for (int p = 0; p < eff; p++) begin
      for (int k = 1; k <= v.calc_n; k++) begin
        @(negedge clk);
        check("calc_en_calc", en_calc, 1);
        if (v.sv_busy) check("busy_s_ready", s_ready, 0);
        if (k == v.calc_n) conv_pass = 1'b1;
      end
      @(negedge clk);
      conv_pass = 1'b0;
      s_valid   = 1'b0;
      check("result_valid", res_valid, 1);
      check("result_en_calc", en_calc, 0);
      // conv_pass toggled during RESULT must not matter.
      if (v.ready_wait > 0) conv_pass = 1'b1;
      for (int w = 0; w < v.ready_wait; w++) begin
        @(negedge clk);
        check("hold_res_valid", res_valid, 1);
        check("hold_en_calc", en_calc, 0);
        check("hold_coeff_load", coeff_load, 0);
      end
      conv_pass = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      if (p != eff - 1) begin
        check("reload_coeff_load", coeff_load, 1);
        check("reload_en_calc", en_calc, 0);
        check("reload_res_valid", res_valid, 0);
        check("reload_phase", phase, p + 1);
      end else begin
        m_hptr = adv(m_hptr);
        check("done_s_ready", s_ready, 1);
        check("done_busy", busy, 0);
        check("done_phase", phase, 0);
        check("done_coef_ptr", coef_ptr, v.base);
        check("done_data_hptr", data_hptr, v.exp_hptr);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int   cnt;
    vec_t rv;
    vecs[0] = '{4'd3, 12'h020, 12'h010, 5, 0, 1'b0, 12'h101};
    vecs[1] = '{4'd1, 12'h020, 12'h010, 2, 0, 1'b0, 12'h102};
    vecs[2] = '{4'd1, 12'h040, 12'h010, 1, 7, 1'b0, 12'h103};
    vecs[3] = '{4'd0, 12'h050, 12'h010, 3, 2, 1'b0, 12'h100};
    vecs[4] = '{4'd1, 12'h060, 12'h010, 4, 0, 1'b1, 12'h101};
    vecs[5] = '{4'd2, 12'hff0, 12'h020, 1, 1, 1'b0, 12'h102};

    rst = 1'b1; s_valid = 1'b0; conv_pass = 1'b0; res_ready = 1'b0;
    cfg_bptr = 12'h100; cfg_lptr = 12'h103; cfg_coef_base = 12'h020;
    cfg_tap_len = 12'h010; cfg_phases = 4'd3;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_hptr = 12'h100;
    check("rst_data_hptr", data_hptr, 12'h100);
    check("rst_coef_ptr", coef_ptr, 12'h020);
    check("rst_s_ready", s_ready, 1);
    check("rst_strobes", {en_init, ringbuf_init, en_calc, coeff_load}, 0);
    check("rst_res", {res_valid, res_last, busy, wdt_err}, 0);
    check("rst_phase", phase, 0);

    conv_pass = 1'b1;
    repeat (2) @(negedge clk);
    conv_pass = 1'b0;
    check("idle_pass_s_ready", s_ready, 1);
    check("idle_pass_busy", busy, 0);

    for (int i = 0; i < 6; i++) do_sample(vecs[i]);

    // Reset in the third CALC cycle aborts without a result.
    cfg_phases = 4'd1;
    wait_ready();
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midcalc_en_calc", en_calc, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_hptr = 12'h100;
    check("midrst_s_ready", s_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_en_calc", en_calc, 0);
    check("midrst_data_hptr", data_hptr, 12'h100);
    @(negedge clk);
    check("midrst_no_result", res_valid, 0);

    // Sample whose conv_pass never arrives.
    wait_ready();
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!en_calc) break;
      cnt++;
    end
`ifdef CTRL_CONVSEQ_WDT_EN
    check("wdt_calc_cycles", cnt, 15);
    check("wdt_err_pulse", wdt_err, 1);
    check("wdt_s_ready", s_ready, 1);
    check("wdt_res_valid", res_valid, 0);
    check("wdt_data_hptr", data_hptr, adv(m_hptr));
    m_hptr = adv(m_hptr);
    @(negedge clk);
    check("wdt_err_single", wdt_err, 0);
`else
    check("nowdt_calc_cycles", cnt, 40);
    check("nowdt_en_calc", en_calc, 1);
    check("nowdt_wdt_err", wdt_err, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_hptr = 12'h100;
    check("nowdt_rst_data_hptr", data_hptr, 12'h100);
`endif

    rv = '{4'd2, 12'h300, 12'h008, 2, 0, 1'b0, adv(m_hptr)};
    do_sample(rv);

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
